// File: rtl/div_seq_ctrl_if.sv
// Start/operand/result bundle between the ALU control path and the divide sequencer.
// The master side is the requester; the slave side is div_seq_ctrl.
interface div_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic [WIDTH-1:0]       RegA;
    logic [WIDTH-1:0]       RegB;
    logic                   busy;
    logic                   done;
    logic                   div_zero;
    logic [2*WIDTH-1:0]     Z;

    modport master (
        output start, RegA, RegB,
        input  busy, done, div_zero, Z
    );

    modport slave (
        input  start, RegA, RegB,
        output busy, done, div_zero, Z
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// Signed restoring divider: one shift/subtract step per clock, then sign fix-up.
// The result is packed as {remainder, quotient}.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; busy low
// S_PREP  | operands latched; take magnitudes or flag divide-by-zero
// S_ITER  | WIDTH restoring steps on {A,Q} against M
// S_FIX   | apply quotient/remainder signs and load Z
// S_DONE  | done pulse; a start here is accepted like in S_IDLE
module div_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          clear,
    div_seq_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 div_zero_q, div_zero_d;
    logic [2*WIDTH-1:0]   z_q, z_d;
    logic [WIDTH-1:0]     opa_q, opa_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic                 qneg_q, qneg_d;
    logic                 rneg_q, rneg_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic [WIDTH+1:0]     a_sh;
    logic [WIDTH+1:0]     diff;

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        z_d        = z_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        a_d        = a_q;
        q_d        = q_q;
        m_d        = m_q;
        cnt_d      = cnt_q;
        a_sh       = {a_q, q_q[WIDTH-1]};
        diff       = a_sh - {2'b00, m_q};

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    opa_d      = bus.RegA;
                    opb_d      = bus.RegB;
                    qneg_d     = bus.RegA[WIDTH-1] ^ bus.RegB[WIDTH-1];
                    rneg_d     = bus.RegA[WIDTH-1];
                    div_zero_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_PREP;
                end else begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_PREP: begin
                if (opb_q == '0) begin
                    div_zero_d = 1'b1;
                    z_d        = {opa_q, {WIDTH{1'b1}}};
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    q_d     = mag(opa_q);
                    m_d     = mag(opb_q);
                    a_d     = '0;
                    cnt_d   = '0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                // Trial subtract one bit wider than A so its sign bit says whether to restore.
                if (!diff[WIDTH+1]) begin
                    a_d = diff[WIDTH:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    a_d = a_sh[WIDTH:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                z_d[WIDTH-1:0]       = qneg_q ? -q_q : q_q;
                z_d[2*WIDTH-1:WIDTH] = rneg_q ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];
                busy_d               = 1'b0;
                done_d               = 1'b1;
                state_d              = S_DONE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            z_q        <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            a_q        <= '0;
            q_q        <= '0;
            m_q        <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            z_q        <= z_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            a_q        <= a_d;
            q_q        <= q_d;
            m_q        <= m_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.Z        = z_q;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed vector table, multi-cycle corner
// sequences, and random operands against a plain-arithmetic reference.
module tb_div_seq_ctrl;
    localparam int W = 32;

    logic clk = 1'b0;
    logic clear;
    int   n_vec = 0;
    int   n_err = 0;
    logic [2*W-1:0] last_z;

    div_seq_ctrl_if #(.WIDTH(W)) bus ();

    div_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] z;
        logic           dz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // C-style truncating division via 64-bit signed arithmetic (covers min/-1 wrap).
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [2*W-1:0] z, output logic dz);
        longint sa, sb, q, r;
        if (b == 0) begin
            z  = {a, {W{1'b1}}};
            dz = 1'b1;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            z  = {r[W-1:0], q[W-1:0]};
            dz = 1'b0;
        end
    endfunction

    // Caller is at a negedge; the following posedge is the accepting edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.RegA  = a;
        bus.RegB  = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.RegA  = $urandom;
        bus.RegB  = $urandom;
    endtask

    // Starts at the negedge of cycle k+1; returns at the negedge of the done cycle.
    task automatic collect(input string tag, input logic [W-1:0] b,
                           input logic [2*W-1:0] ez, input logic edz, input bit poke);
        int  n, bcnt, lat;
        bit  seen, zchg;
        n = 1; bcnt = 0; lat = 0; seen = 0; zchg = 0;
        check({tag, ".dz_clear"}, 64'(bus.div_zero), 64'(0));
        check({tag, ".z_hold_accept"}, bus.Z, last_z);
        while (!seen && n <= 60) begin
            if (bus.busy) bcnt++;
            if (bus.done) begin
                seen = 1;
                lat  = n;
            end else if (bus.Z !== last_z) begin
                zchg = 1;
            end
            if (poke && n == 10) begin
                bus.start = 1'b1;
                bus.RegA  = 1;
                bus.RegB  = 1;
            end
            if (poke && n == 11) begin
                bus.start = 1'b0;
                bus.RegA  = $urandom;
                bus.RegB  = $urandom;
            end
            if (!seen) begin
                @(negedge clk);
                n++;
            end
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s.timeout: no done within 60 cycles, expected at %0d", tag, (b == 0) ? 2 : 35);
        end else begin
            check({tag, ".latency"}, 64'(lat), (b == 0) ? 64'd2 : 64'd35);
            check({tag, ".busy_cycles"}, 64'(bcnt), (b == 0) ? 64'd1 : 64'd34);
            check({tag, ".Z"}, bus.Z, ez);
            check({tag, ".div_zero"}, 64'(bus.div_zero), 64'(edz));
            check({tag, ".z_stable"}, 64'(zchg), 64'd0);
        end
        last_z = ez;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[10];
        logic [2*W-1:0] ez;
        logic       edz;
        logic [W-1:0] ra, rb;
        int         sel;
        bit         spurious;

        tbl[0] = '{32'd100,        32'd7,          64'h00000002_0000000E, 1'b0};
        tbl[1] = '{32'hFFFFFF9C,   32'd7,          64'hFFFFFFFE_FFFFFFF2, 1'b0};
        tbl[2] = '{32'd100,        32'hFFFFFFF9,   64'h00000002_FFFFFFF2, 1'b0};
        tbl[3] = '{32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 1'b0};
        tbl[4] = '{32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 1'b0};
        tbl[5] = '{32'h80000000,   32'd1,          64'h00000000_80000000, 1'b0};
        tbl[6] = '{32'd7,          32'd100,        64'h00000007_00000000, 1'b0};
        tbl[7] = '{32'd5,          32'd0,          64'h00000005_FFFFFFFF, 1'b1};
        tbl[8] = '{32'd9,          32'd3,          64'h00000000_00000003, 1'b0};
        tbl[9] = '{32'h7FFFFFFF,   32'h80000000,   64'h7FFFFFFF_00000000, 1'b0};

        clear     = 1'b1;
        bus.start = 1'b0;
        bus.RegA  = '0;
        bus.RegB  = '0;
        last_z    = '0;
        repeat (3) @(negedge clk);
        check("reset.busy", 64'(bus.busy), 64'd0);
        check("reset.done", 64'(bus.done), 64'd0);
        check("reset.div_zero", 64'(bus.div_zero), 64'd0);
        check("reset.Z", bus.Z, 64'd0);
        clear = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            launch(tbl[i].a, tbl[i].b);
            collect($sformatf("vec%0d", i), tbl[i].b, tbl[i].z, tbl[i].dz, 1'b0);
            @(negedge clk);
            check($sformatf("vec%0d.done_pulse", i), 64'(bus.done), 64'd0);
        end

        // start during ITER must be ignored; then a start in the DONE cycle runs back-to-back.
        launch(32'd50, 32'd5);
        collect("ignore", 32'd5, 64'h00000000_0000000A, 1'b0, 1'b1);
        launch(32'd1, 32'd1);
        collect("b2b", 32'd1, 64'h00000000_00000001, 1'b0, 1'b0);
        @(negedge clk);

        // Abort at ITER step 10 (cycle k+12).
        launch(32'd100, 32'd7);
        repeat (11) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("abort.busy", 64'(bus.busy), 64'd0);
        check("abort.done", 64'(bus.done), 64'd0);
        check("abort.Z", bus.Z, 64'd0);
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) spurious = 1;
        end
        check("abort.no_spurious_done", 64'(spurious), 64'd0);
        last_z = '0;
        launch(32'd100, 32'd7);
        collect("after_abort", 32'd7, 64'h00000002_0000000E, 1'b0, 1'b0);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 7);
            ra  = $urandom;
            rb  = $urandom;
            if (sel == 0) rb = '0;
            else if (sel == 1) rb = 32'($urandom_range(1, 20));
            else if (sel == 2) rb = -32'($urandom_range(1, 20));
            else if (sel == 3) ra = 32'h80000000;
            else if (sel == 4) rb = rb >> $urandom_range(1, 31);
            model(ra, rb, ez, edz);
            launch(ra, rb);
            collect($sformatf("rnd%0d", i), rb, ez, edz, 1'b0);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
